// File: rtl/uart_host_cmd_mstr.sv
// Host UART command master: sends a 24-bit command as three 8N1 frames (MSB byte first)
// and receives response bytes on an independent full-duplex receiver.
// Optional build macro RESP_TIMEOUT_EN adds a response timeout timer; otherwise resp_tmo is 0.
module uart_host_cmd_mstr #(
  parameter int BAUD_DIV    = 2604,
  parameter int TIMEOUT_CYC = 2000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [23:0] cmd,
  input  logic        send_cmd,
  output logic        TX,
  input  logic        RX,
  output logic        cmd_sent,
  output logic        busy,
  output logic [7:0]  resp,
  output logic        resp_rdy,
  input  logic        clr_resp_rdy,
  output logic        resp_tmo
);

  localparam int            CW        = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BIT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(BAUD_DIV / 2 - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
  typedef enum logic [1:0] {R_IDLE, R_START, R_DATA, R_STOP} rx_state_t;

  // ---------------- transmitter ----------------
  tx_state_t     tx_state, tx_state_n;
  logic [CW-1:0] tx_cnt, tx_cnt_n;
  logic [2:0]    tx_bit, tx_bit_n;
  logic [1:0]    byte_idx, byte_idx_n;
  logic [23:0]   shadow, shadow_n;
  logic          tx_q, tx_n;
  logic          busy_q, busy_n;
  logic          sent_q, sent_n;
  logic [7:0]    cur_byte;
  logic          tx_bit_last;
  logic          accept;
  logic          cmd_done;

  assign tx_bit_last = (tx_cnt == BIT_LAST);

  // Select the byte currently on the wire, most significant byte first.
  always_comb begin
    case (byte_idx)
      2'd0:    cur_byte = shadow[23:16];
      2'd1:    cur_byte = shadow[15:8];
      default: cur_byte = shadow[7:0];
    endcase
  end

  // TX next-state and output logic; TX is registered so the line is glitch-free.
  always_comb begin
    tx_state_n = tx_state;
    tx_cnt_n   = tx_cnt;
    tx_bit_n   = tx_bit;
    byte_idx_n = byte_idx;
    shadow_n   = shadow;
    tx_n       = tx_q;
    busy_n     = busy_q;
    sent_n     = sent_q;
    accept     = 1'b0;
    cmd_done   = 1'b0;
    if (tx_state != IDLE) begin
      tx_cnt_n = tx_bit_last ? '0 : tx_cnt + CW'(1);
    end
    case (tx_state)
      IDLE: begin
        tx_n = 1'b1;
        if (send_cmd) begin
          accept     = 1'b1;
          shadow_n   = cmd;
          byte_idx_n = 2'd0;
          sent_n     = 1'b0;
          busy_n     = 1'b1;
          tx_n       = 1'b0;
          tx_cnt_n   = '0;
          tx_state_n = START;
        end
      end
      START: begin
        if (tx_bit_last) begin
          tx_state_n = DATA;
          tx_bit_n   = 3'd0;
          tx_n       = cur_byte[0];
        end
      end
      DATA: begin
        if (tx_bit_last) begin
          if (tx_bit == 3'd7) begin
            tx_state_n = STOP;
            tx_n       = 1'b1;
          end else begin
            tx_bit_n = tx_bit + 3'd1;
            tx_n     = cur_byte[tx_bit + 3'd1];
          end
        end
      end
      STOP: begin
        if (tx_bit_last) begin
          if (byte_idx != 2'd2) begin
            byte_idx_n = byte_idx + 2'd1;
            tx_state_n = START;
            tx_n       = 1'b0;
          end else begin
            cmd_done   = 1'b1;
            tx_state_n = IDLE;
            busy_n     = 1'b0;
            sent_n     = 1'b1;
            tx_n       = 1'b1;
          end
        end
      end
      default: tx_state_n = IDLE;
    endcase
  end

  // TX state register; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      tx_state <= IDLE;
      tx_cnt   <= '0;
      tx_bit   <= 3'd0;
      byte_idx <= 2'd0;
      shadow   <= 24'h0;
      tx_q     <= 1'b1;
      busy_q   <= 1'b0;
      sent_q   <= 1'b0;
    end else begin
      tx_state <= tx_state_n;
      tx_cnt   <= tx_cnt_n;
      tx_bit   <= tx_bit_n;
      byte_idx <= byte_idx_n;
      shadow   <= shadow_n;
      tx_q     <= tx_n;
      busy_q   <= busy_n;
      sent_q   <= sent_n;
    end
  end

  assign TX       = tx_q;
  assign busy     = busy_q;
  assign cmd_sent = sent_q;

  // ---------------- receiver ----------------
  rx_state_t     rx_state, rx_state_n;
  logic [CW-1:0] rx_cnt, rx_cnt_n;
  logic [2:0]    rx_bit, rx_bit_n;
  logic [7:0]    rx_shift, rx_shift_n;
  logic          rx_s1, rx_s2, rx_prev;
  logic          byte_ok;
  logic [7:0]    resp_q;
  logic          rdy_q;

  // Two-flop synchroniser plus a delayed copy for falling-edge detection.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_s1   <= RX;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
    end
  end

  // RX next-state logic: mid-bit sampling, glitch rejection on the start bit.
  always_comb begin
    rx_state_n = rx_state;
    rx_cnt_n   = rx_cnt + CW'(1);
    rx_bit_n   = rx_bit;
    rx_shift_n = rx_shift;
    byte_ok    = 1'b0;
    case (rx_state)
      R_IDLE: begin
        rx_cnt_n = '0;
        if (rx_prev && !rx_s2) begin
          rx_state_n = R_START;
        end
      end
      R_START: begin
        if (rx_cnt == HALF_LAST) begin
          rx_cnt_n   = '0;
          rx_bit_n   = 3'd0;
          rx_state_n = rx_s2 ? R_IDLE : R_DATA;
        end
      end
      R_DATA: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          rx_shift_n = {rx_s2, rx_shift[7:1]};
          if (rx_bit == 3'd7) begin
            rx_state_n = R_STOP;
          end else begin
            rx_bit_n = rx_bit + 3'd1;
          end
        end
      end
      R_STOP: begin
        if (rx_cnt == BIT_LAST) begin
          rx_cnt_n   = '0;
          byte_ok    = rx_s2;
          rx_state_n = R_IDLE;
        end
      end
      default: rx_state_n = R_IDLE;
    endcase
  end

  // RX state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_state <= R_IDLE;
      rx_cnt   <= '0;
      rx_bit   <= 3'd0;
      rx_shift <= 8'h00;
    end else begin
      rx_state <= rx_state_n;
      rx_cnt   <= rx_cnt_n;
      rx_bit   <= rx_bit_n;
      rx_shift <= rx_shift_n;
    end
  end

  // Response holding register; a new byte beats a simultaneous clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_q <= 8'h00;
      rdy_q  <= 1'b0;
    end else if (byte_ok) begin
      resp_q <= rx_shift;
      rdy_q  <= 1'b1;
    end else if (clr_resp_rdy) begin
      rdy_q  <= 1'b0;
    end
  end

  assign resp     = resp_q;
  assign resp_rdy = rdy_q;

  // ---------------- optional response timeout ----------------
`ifdef RESP_TIMEOUT_EN
  logic [31:0] tmr;
  logic        tmr_run;
  logic        tmo_q;

  // Timer runs from cmd_sent until the first good byte or expiry.
  always_ff @(posedge clk) begin
    if (rst) begin
      tmr     <= 32'd0;
      tmr_run <= 1'b0;
      tmo_q   <= 1'b0;
    end else if (accept) begin
      tmr     <= 32'd0;
      tmr_run <= 1'b0;
      tmo_q   <= 1'b0;
    end else if (cmd_done) begin
      tmr     <= 32'd0;
      tmr_run <= 1'b1;
    end else if (tmr_run) begin
      if (byte_ok) begin
        tmr_run <= 1'b0;
      end else begin
        tmr <= tmr + 32'd1;
        if (tmr + 32'd1 == 32'(TIMEOUT_CYC)) begin
          tmo_q   <= 1'b1;
          tmr_run <= 1'b0;
        end
      end
    end
  end

  assign resp_tmo = tmo_q;
`else
  logic unused_tmo_cfg;
  assign unused_tmo_cfg = accept ^ cmd_done ^ (|32'(TIMEOUT_CYC));
  assign resp_tmo       = 1'b0;
`endif

endmodule

// File: tb/tb_uart_host_cmd_mstr.sv
module tb_uart_host_cmd_mstr;
  localparam int B   = 16;
  localparam int TMO = 100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [23:0] cmd = 24'h0;
  logic        send_cmd = 1'b0;
  logic        TX;
  logic        RX;
  logic        rx_drv = 1'b1;
  logic        loopback = 1'b0;
  logic        cmd_sent, busy, resp_rdy, resp_tmo;
  logic [7:0]  resp;
  logic        clr_man = 1'b0;
  logic        clr_auto = 1'b0;
  logic        auto_clr = 1'b0;
  logic        clr_resp_rdy;

  int checks = 0;
  int errors = 0;

  logic [7:0] line_q[$];
  logic [7:0] got_q[$];

  assign RX           = loopback ? TX : rx_drv;
  assign clr_resp_rdy = auto_clr ? clr_auto : clr_man;

  uart_host_cmd_mstr #(.BAUD_DIV(B), .TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .cmd(cmd), .send_cmd(send_cmd), .TX(TX), .RX(RX),
    .cmd_sent(cmd_sent), .busy(busy), .resp(resp), .resp_rdy(resp_rdy),
    .clr_resp_rdy(clr_resp_rdy), .resp_tmo(resp_tmo)
  );

  always #5 clk = ~clk;

  // Collect every received byte and acknowledge it when auto-clear is on.
  always @(negedge clk) begin
    if (clr_auto) clr_auto = 1'b0;
    else if (auto_clr && resp_rdy) begin
      got_q.push_back(resp);
      clr_auto = 1'b1;
    end
  end

  // Behavioural 8N1 decoder watching the TX line.
  initial begin : line_dec
    logic       prev;
    logic [7:0] b;
    wait (rst == 1'b0);
    prev = 1'b1;
    forever begin
      @(negedge clk);
      if (prev === 1'b1 && TX === 1'b0) begin
        repeat (B / 2 - 1) @(negedge clk);
        if (TX === 1'b0) begin
          for (int i = 0; i < 8; i++) begin
            repeat (B) @(negedge clk);
            b[i] = TX;
          end
          repeat (B) @(negedge clk);
          if (TX === 1'b1) line_q.push_back(b);
        end
      end
      prev = TX;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stopb);
    rx_drv = 1'b0;
    tick(B);
    for (int i = 0; i < 8; i++) begin
      rx_drv = d[i];
      tick(B);
    end
    rx_drv = stopb;
    tick(B);
    rx_drv = 1'b1;
  endtask

  // Send one command, optionally poking a second send_cmd mid-flight; check timing and bytes.
  task automatic run_cmd(input logic [23:0] c, input int poke_at);
    int         cyc;
    logic [7:0] exp_b;
    line_q.delete();
    got_q.delete();
    cmd = c;
    send_cmd = 1'b1;
    cyc = 0;
    while (cyc <= 40 * B) begin
      @(negedge clk);
      cyc++;
      send_cmd = 1'b0;
      if (cyc == 1) begin
        checks++;
        if (busy !== 1'b1 || cmd_sent !== 1'b0 || TX !== 1'b0) begin
          errors++;
          $display("FAIL start_state busy=%b cmd_sent=%b tx=%b required 1 0 0", busy, cmd_sent, TX);
        end
        cmd = 24'($urandom);
      end
      if (poke_at != 0 && cyc == poke_at) begin
        cmd = 24'hFFFFFF;
        send_cmd = 1'b1;
      end
      if (cmd_sent === 1'b1) break;
    end
    checks++;
    if (cyc != 30 * B + 1) begin
      errors++;
      $display("FAIL cmd_sent_latency got %0d required %0d", cyc, 30 * B + 1);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL busy_after got %b required 0", busy);
    end
    tick(2 * B);
    checks++;
    if (line_q.size() != 3 || (loopback && got_q.size() != 3)) begin
      errors++;
      $display("FAIL byte_count line=%0d rx=%0d required 3", line_q.size(), got_q.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        exp_b = 8'((c >> (16 - 8 * i)) & 24'hFF);
        checks++;
        if (line_q[i] !== exp_b || (loopback && got_q[i] !== exp_b)) begin
          errors++;
          $display("FAIL byte%0d line=%h rx=%h required %h", i, line_q[i], got_q[i], exp_b);
        end
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick(3);
    checks++;
    if (TX !== 1'b1 || busy !== 1'b0 || cmd_sent !== 1'b0 || resp !== 8'h00 ||
        resp_rdy !== 1'b0 || resp_tmo !== 1'b0) begin
      errors++;
      $display("FAIL reset_values tx=%b busy=%b sent=%b resp=%h rdy=%b tmo=%b required 1 0 0 00 0 0",
               TX, busy, cmd_sent, resp, resp_rdy, resp_tmo);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_loopback;
    loopback = 1'b1;
    auto_clr = 1'b1;
    tick(2);
    run_cmd(24'h082ABB, 0);
    for (int k = 0; k < 3; k++) run_cmd(24'($urandom), 0);
  endtask

  task automatic test_busy_ignore;
    run_cmd(24'h050002, 100);
    tick(12 * B);
    checks++;
    if (line_q.size() != 3 || busy !== 1'b0 || cmd_sent !== 1'b1) begin
      errors++;
      $display("FAIL busy_ignore bytes=%0d busy=%b sent=%b required 3 0 1", line_q.size(), busy, cmd_sent);
    end
  endtask

  task automatic test_rx_clr;
    bit seen;
    loopback = 1'b0;
    auto_clr = 1'b0;
    clr_man = 1'b1;
    tick(2);
    checks++;
    if (resp_rdy !== 1'b0) begin
      errors++;
      $display("FAIL clr_idle rdy=%b required 0", resp_rdy);
    end
    seen = 1'b0;
    fork
      send_frame(8'hA5, 1'b1);
      begin
        for (int n = 0; n < 12 * B; n++) begin
          @(negedge clk);
          if (resp_rdy === 1'b1) begin
            seen = 1'b1;
            clr_man = 1'b0;
            break;
          end
        end
      end
    join
    clr_man = 1'b0;
    tick(2);
    checks++;
    if (!seen || resp_rdy !== 1'b1 || resp !== 8'hA5) begin
      errors++;
      $display("FAIL set_beats_clear seen=%0d rdy=%b resp=%h required 1 1 a5", seen, resp_rdy, resp);
    end
    send_frame(8'h3C, 1'b0);
    tick(B);
    checks++;
    if (resp !== 8'hA5 || resp_rdy !== 1'b1) begin
      errors++;
      $display("FAIL framing_error resp=%h rdy=%b required a5 1", resp, resp_rdy);
    end
    clr_man = 1'b1;
    tick(1);
    clr_man = 1'b0;
    checks++;
    if (resp_rdy !== 1'b0) begin
      errors++;
      $display("FAIL clear rdy=%b required 0", resp_rdy);
    end
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    tick(B);
    checks++;
    if (resp !== 8'h22 || resp_rdy !== 1'b1) begin
      errors++;
      $display("FAIL overwrite resp=%h rdy=%b required 22 1", resp, resp_rdy);
    end
    clr_man = 1'b1;
    tick(1);
    clr_man = 1'b0;
  endtask

  task automatic test_glitch_back_to_back;
    logic [7:0] exp_q[$];
    logic [7:0] d;
    rx_drv = 1'b0;
    tick(4);
    rx_drv = 1'b1;
    tick(3 * B);
    checks++;
    if (resp_rdy !== 1'b0) begin
      errors++;
      $display("FAIL glitch rdy=%b required 0", resp_rdy);
    end
    auto_clr = 1'b1;
    got_q.delete();
    exp_q = '{8'h01, 8'h02};
    for (int k = 0; k < 4; k++) exp_q.push_back(8'($urandom));
    foreach (exp_q[i]) begin
      d = exp_q[i];
      send_frame(d, 1'b1);
    end
    tick(4);
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL b2b_count got %0d required %0d", got_q.size(), exp_q.size());
    end else begin
      foreach (exp_q[i]) begin
        checks++;
        if (got_q[i] !== exp_q[i]) begin
          errors++;
          $display("FAIL b2b_byte%0d got %h required %h", i, got_q[i], exp_q[i]);
        end
      end
    end
    auto_clr = 1'b0;
  endtask

  task automatic test_reset_mid;
    loopback = 1'b1;
    auto_clr = 1'b1;
    cmd = 24'h000000;
    send_cmd = 1'b1;
    tick(1);
    send_cmd = 1'b0;
    tick(3 * B);
    checks++;
    if (TX !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL data_phase tx=%b busy=%b required 0 1", TX, busy);
    end
    rst = 1'b1;
    tick(1);
    checks++;
    if (TX !== 1'b1 || busy !== 1'b0 || cmd_sent !== 1'b0 || resp_rdy !== 1'b0) begin
      errors++;
      $display("FAIL reset_abort tx=%b busy=%b sent=%b rdy=%b required 1 0 0 0", TX, busy, cmd_sent, resp_rdy);
    end
    rst = 1'b0;
    tick(12 * B);
    run_cmd(24'h070000, 0);
  endtask

  task automatic test_timeout;
    int cyc;
    loopback = 1'b0;
    auto_clr = 1'b0;
    rx_drv = 1'b1;
    cmd = 24'h123456;
    send_cmd = 1'b1;
    tick(1);
    send_cmd = 1'b0;
    cyc = 0;
    while (cmd_sent !== 1'b1 && cyc < 40 * B) begin
      tick(1);
      cyc++;
    end
`ifdef RESP_TIMEOUT_EN
    cyc = 0;
    while (resp_tmo !== 1'b1 && cyc < 4 * TMO) begin
      tick(1);
      cyc++;
    end
    checks++;
    if (cyc != TMO) begin
      errors++;
      $display("FAIL timeout_latency got %0d required %0d", cyc, TMO);
    end
    cmd = 24'h654321;
    send_cmd = 1'b1;
    tick(1);
    send_cmd = 1'b0;
    checks++;
    if (resp_tmo !== 1'b0) begin
      errors++;
      $display("FAIL timeout_clear tmo=%b required 0", resp_tmo);
    end
    tick(30 * B - 110);
    send_frame(8'h5A, 1'b1);
    tick(200);
    checks++;
    if (resp_tmo !== 1'b0 || resp !== 8'h5A) begin
      errors++;
      $display("FAIL timely_resp tmo=%b resp=%h required 0 5a", resp_tmo, resp);
    end
`else
    tick(3 * TMO);
    checks++;
    if (resp_tmo !== 1'b0) begin
      errors++;
      $display("FAIL no_timer tmo=%b required 0", resp_tmo);
    end
`endif
  endtask

  initial begin
    test_reset();
    test_loopback();
    test_busy_ignore();
    test_rx_clr();
    test_glitch_back_to_back();
    test_reset_mid();
    test_timeout();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
